lz4_hash_lookup: RTL and testbench

- Upstream stage of the match path, sitting between the input byte window and the relative-address converter.
- For each 4-byte sequence it hashes the bytes, reads the hash table for the previous absolute address with the same hash, and writes the current absolute address into that entry.
- It presents that previous address to the converter as abs_addr_out, with a hit flag.
- It owns table invalidation at reset and at each new block.

---
 rtl/lz4_hash_lookup.sv | 207 ++++++++++++++++++++
 tb/tb_lz4_hash_lookup.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz4_hash_lookup.sv
// ---------------------------------------------------------------------------
// lz4_hash_lookup
//
// Purpose:
//   Match-path front end. Every accepted 4-byte sequence is hashed
//   multiplicatively. The hash table is read for the most recent absolute
//   address that had the same hash, and the current address is then written
//   into that entry. The previous address is presented downstream with a hit
//   flag. Hash collisions are reported as hits; the converter stage verifies
//   the match.
//   The block also invalidates the table, one entry per cycle, after reset
//   and on every clr pulse (start of a new block).
//
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   clr          : one-cycle pulse, aborts any lookup and re-invalidates table
//   in_valid     : a sequence is offered
//   in_ready     : sequence accepted this cycle (only in IDLE)
//   in_word      : 4 window bytes, byte0 in [31:24]
//   in_addr      : absolute address of byte0
//   out_valid    : a lookup result is held
//   out_ready    : downstream accepts the result
//   abs_addr_out : previous address stored under this hash, 0 on a miss
//   cand_hit     : the table entry was valid
//   cur_addr_out : in_addr of this lookup
//   cur_word_out : in_word of this lookup
// ---------------------------------------------------------------------------
module lz4_hash_lookup #(
  parameter int          HASH_BITS = 12,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] HASH_MUL  = 32'h9E3779B1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] abs_addr_out,
  output logic              cand_hit,
  output logic [ADDR_W-1:0] cur_addr_out,
  output logic [31:0]       cur_word_out
);

  localparam int DEPTH = 1 << HASH_BITS;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_RESP,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [HASH_BITS-1:0]  clr_cnt_q, clr_cnt_d;
  logic [HASH_BITS-1:0]  h_q, h_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     abs_q, abs_d;
  logic                  hit_q, hit_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  // Hash of the offered word: low 32 bits of the product, top HASH_BITS kept.
  logic [31:0]           hash_prod;
  logic [HASH_BITS-1:0]  h_in;

  assign hash_prod = in_word * HASH_MUL;
  assign h_in      = hash_prod[31 -: HASH_BITS];

  // Table entry layout: {valid, address}.
  logic [ADDR_W:0]       table_mem [DEPTH];
  logic [HASH_BITS-1:0]  mem_idx;
  logic                  mem_we;
  logic [ADDR_W:0]       mem_wdata;
  logic [ADDR_W:0]       rd_data_q, rd_data_d;

  // Single table port. The sweep counter owns it during CLEAR, otherwise the
  // registered hash does. A clr pulse suppresses the write, so an aborted
  // RESP leaves the table untouched.
  always_comb begin
    mem_idx   = h_q;
    mem_we    = 1'b0;
    mem_wdata = {1'b1, addr_q};
    if (state_q == S_CLEAR) begin
      mem_idx   = clr_cnt_q;
      mem_wdata = '0;
    end
    if (rst_n && !clr && (state_q == S_CLEAR || state_q == S_RESP)) begin
      mem_we = 1'b1;
    end
    rd_data_d = table_mem[mem_idx];
  end

  // Synchronous-read storage. The write in RESP lands at least two cycles
  // before the next READ, so back-to-back lookups see fresh data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      table_mem[mem_idx] <= mem_wdata;
    end
    rd_data_q <= rd_data_d;
  end

  // Next-state logic. clr overrides every state: any pending result is
  // dropped, the captured lookup data is left as is, and the sweep restarts.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    h_d         = h_q;
    word_d      = word_q;
    addr_d      = addr_q;
    abs_d       = abs_q;
    hit_d       = hit_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          word_d     = in_word;
          addr_d     = in_addr;
          h_d        = h_in;
          in_ready_d = 1'b0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        hit_d       = rd_data_q[ADDR_W];
        abs_d       = rd_data_q[ADDR_W] ? rd_data_q[ADDR_W-1:0] : '0;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase

    if (clr) begin
      state_d     = S_CLEAR;
      clr_cnt_d   = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b0;
      word_d      = word_q;
      addr_d      = addr_q;
      h_d         = h_q;
      abs_d       = abs_q;
      hit_d       = hit_q;
    end
  end

  // State and registered outputs. Reset always restarts the sweep, even in
  // the middle of a previous one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      h_q         <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      abs_q       <= '0;
      hit_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      h_q         <= h_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      abs_q       <= abs_d;
      hit_q       <= hit_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign abs_addr_out = abs_q;
  assign cand_hit     = hit_q;
  assign cur_addr_out = addr_q;
  assign cur_word_out = word_q;

endmodule

// File: tb/tb_lz4_hash_lookup.sv
// ---------------------------------------------------------------------------
// tb_lz4_hash_lookup
//
// Self-checking bench for lz4_hash_lookup. A behavioural table model (plain
// arrays indexed by the multiplicative hash) produces the expected result of
// every accepted sequence. A single monitor checks every cycle in which
// out_valid is high against that model. Directed literal checks cover reset,
// miss/hit, backpressure, collision and clr abort.
// ---------------------------------------------------------------------------
module tb_lz4_hash_lookup;

  localparam int HB    = 12;
  localparam int DEPTH = 1 << HB;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] abs_addr_out;
  logic        cand_hit;
  logic [31:0] cur_addr_out;
  logic [31:0] cur_word_out;

  int checks;
  int failures;

  lz4_hash_lookup #(
    .HASH_BITS(HB),
    .ADDR_W(32),
    .HASH_MUL(32'h9E3779B1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_word(in_word),
    .in_addr(in_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .abs_addr_out(abs_addr_out),
    .cand_hit(cand_hit),
    .cur_addr_out(cur_addr_out),
    .cur_word_out(cur_word_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparison helpers
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    checks++;
    failures++;
    $display("[TB] FAIL %s %s", name, what);
  endtask

  // Reference model
  function automatic int modelHash(input logic [31:0] w);
    logic [63:0] p;
    p = {32'd0, w} * 64'h0000_0000_9E37_79B1;
    return int'(p[31:0] >> (32 - HB));
  endfunction

  typedef struct {
    logic        hit;
    logic [31:0] prev;
    logic [31:0] addr;
    logic [31:0] word;
    int          acc;
  } exp_t;

  bit          m_valid [DEPTH];
  logic [31:0] m_addr  [DEPTH];
  exp_t        expq[$];
  int          cyc;
  bit          prev_ov;
  int          hits_seen;

  // out_ready source: 0 = low, 1 = high, 2 = random
  int ready_mode;

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom % 3) != 0;
    endcase
  end

  // Monitor: check held results against the model, then advance the model
  // with whatever handshakes happen on the coming edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        reportFail("mon_unexpected_valid", "actual=out_valid required=no_result");
      end else begin
        checkOutput("mon_cand_hit", 64'(cand_hit), 64'(expq[0].hit));
        checkOutput("mon_abs_addr", 64'(abs_addr_out), 64'(expq[0].prev));
        checkOutput("mon_cur_addr", 64'(cur_addr_out), 64'(expq[0].addr));
        checkOutput("mon_cur_word", 64'(cur_word_out), 64'(expq[0].word));
        checkOutput("mon_in_ready_low", 64'(in_ready), 64'd0);
        if (!prev_ov) begin
          checkOutput("mon_latency", 64'(cyc - expq[0].acc), 64'd3);
          if (expq[0].hit) hits_seen++;
        end
      end
    end
    prev_ov = (out_valid === 1'b1);

    if (rst_n !== 1'b1 || clr === 1'b1) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      expq.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1 && expq.size() > 0) begin
        void'(expq.pop_front());
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        int   h;
        exp_t e;
        h      = modelHash(in_word);
        e.hit  = m_valid[h];
        e.prev = m_valid[h] ? m_addr[h] : 32'd0;
        e.addr = in_addr;
        e.word = in_word;
        e.acc  = cyc;
        expq.push_back(e);
        m_valid[h] = 1'b1;
        m_addr[h]  = in_addr;
      end
    end
  end

  // Stimulus helpers (entered and left just after a rising edge)
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] a);
    bit done;
    done     = 1'b0;
    in_word  = w;
    in_addr  = a;
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = $urandom;
    in_addr  = $urandom;
    if (!done) reportFail("accept_timeout", "actual=not_accepted required=accepted");
  endtask

  task automatic waitOutValid(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) reportFail(name, "actual=no_out_valid required=out_valid");
  endtask

  task automatic toEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic countClear(input string name);
    int cnt;
    bit ov_seen;
    cnt     = 0;
    ov_seen = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen = 1'b1;
      if (in_ready === 1'b1) break;
      cnt++;
    end
    checkOutput({name, "_cycles"}, 64'(cnt), 64'd4096);
    checkOutput({name, "_out_valid_low"}, 64'(ov_seen), 64'd0);
  endtask

  logic [31:0] w1, w2, snap_abs, snap_addr, snap_word;
  logic        snap_hit;
  logic [31:0] pool [24];

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    prev_ov    = 1'b0;
    hits_seen  = 0;
    ready_mode = 1;
    rst_n      = 1'b0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;
    in_addr    = '0;
    out_ready  = 1'b0;

    // Reset and initial sweep
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_outputs", {abs_addr_out, cur_addr_out}, 64'd0);
    checkOutput("rst_word_hit", {31'd0, cand_hit, cur_word_out}, 64'd0);
    rst_n = 1'b1;
    countClear("reset_clear");
    toEdge();

    // Miss, then hits on the same word
    applyStimulus(32'h61626364, 32'h10);
    waitOutValid("t2a_wait");
    checkOutput("t2a_hit", 64'(cand_hit), 64'd0);
    checkOutput("t2a_abs", 64'(abs_addr_out), 64'd0);
    checkOutput("t2a_cur_addr", 64'(cur_addr_out), 64'h10);
    checkOutput("t2a_cur_word", 64'(cur_word_out), 64'h61626364);
    toEdge();
    applyStimulus(32'h61626364, 32'h20);
    waitOutValid("t2b_wait");
    checkOutput("t2b_hit", 64'(cand_hit), 64'd1);
    checkOutput("t2b_abs", 64'(abs_addr_out), 64'h10);
    toEdge();
    applyStimulus(32'h61626364, 32'h35);
    waitOutValid("t2c_wait");
    checkOutput("t2c_abs", 64'(abs_addr_out), 64'h20);
    checkOutput("t2c_cur_addr", 64'(cur_addr_out), 64'h35);
    toEdge();

    // Backpressure
    ready_mode = 0;
    toEdge();
    applyStimulus(32'hCAFEF00D, 32'h500);
    waitOutValid("bp_wait");
    snap_abs  = abs_addr_out;
    snap_addr = cur_addr_out;
    snap_word = cur_word_out;
    snap_hit  = cand_hit;
    checkOutput("bp_cur_addr", 64'(snap_addr), 64'h500);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_addrs", {abs_addr_out, cur_addr_out}, {snap_abs, snap_addr});
      checkOutput("bp_hold_flags", {29'd0, cand_hit, out_valid, in_ready, cur_word_out},
                  {29'd0, snap_hit, 1'b1, 1'b0, snap_word});
    end
    ready_mode = 1;
    @(negedge clk);
    checkOutput("bp_valid_at_ready", 64'(out_valid), 64'd1);
    @(negedge clk);
    checkOutput("bp_valid_fall", 64'(out_valid), 64'd0);
    checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);
    toEdge();

    // Collision: two distinct words with equal hash
    w1 = $urandom;
    w2 = w1;
    for (int k = 1; k < (1 << 22); k++) begin
      logic [31:0] cand;
      cand = w1 + 32'(k);
      if (modelHash(cand) == modelHash(w1)) begin
        w2 = cand;
        break;
      end
    end
    if (w2 == w1) reportFail("coll_search", "actual=none required=found");
    applyStimulus(w1, 32'h100);
    waitOutValid("coll_a_wait");
    toEdge();
    applyStimulus(w2, 32'h200);
    waitOutValid("coll_b_wait");
    checkOutput("coll_hit", 64'(cand_hit), 64'd1);
    checkOutput("coll_abs", 64'(abs_addr_out), 64'h100);
    checkOutput("coll_cur_word", 64'(cur_word_out), 64'(w2));
    toEdge();

    // clr during RESP aborts the lookup and re-invalidates the table
    applyStimulus(32'h0BADBEEF, 32'h300);
    toEdge();
    clr = 1'b1;
    toEdge();
    clr = 1'b0;
    countClear("clr_clear");
    toEdge();
    applyStimulus(32'h61626364, 32'h40);
    waitOutValid("t5_wait");
    checkOutput("t5_hit", 64'(cand_hit), 64'd0);
    checkOutput("t5_abs", 64'(abs_addr_out), 64'd0);
    checkOutput("t5_cur_addr", 64'(cur_addr_out), 64'h40);
    toEdge();

    // Randomised stream with random backpressure
    for (int i = 0; i < 24; i++) pool[i] = $urandom;
    ready_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] w;
      w = (($urandom % 4) == 0) ? 32'($urandom) : pool[$urandom % 24];
      applyStimulus(w, $urandom);
      repeat ($urandom % 2) toEdge();
    end
    ready_mode = 1;
    for (int n = 0; n < 100 && expq.size() > 0; n++) @(negedge clk);
    checkOutput("rand_drained", 64'(expq.size()), 64'd0);
    checkOutput("rand_hits_seen", 64'(hits_seen > 0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
